// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: merges the core instruction and data ports onto one split-transaction memory port.
// Define CORE_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority, data over instruction.
module core_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_val,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ack,
  output logic [31:0] i_ack_rdata,
  input  logic        d_req_val,
  input  logic [31:0] d_req_addr,
  input  logic [2:0]  d_req_cop,
  input  logic [31:0] d_req_wdata,
  input  logic [2:0]  d_req_size,
  output logic        d_req_ack,
  output logic [31:0] d_ack_rdata,
  output logic        m_req_val,
  input  logic        m_req_rdy,
  output logic [31:0] m_req_addr,
  output logic [2:0]  m_req_cop,
  output logic [31:0] m_req_wdata,
  output logic [2:0]  m_req_size,
  output logic        m_req_src,
  input  logic        m_ack_val,
  input  logic [31:0] m_ack_rdata,
  output logic        err_unexp_ack,
  output logic        err_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  state_t r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_i_rdata, r_d_rdata;
  logic [2:0] r_cop, r_size;
  logic [CW-1:0] r_cnt;
  logic r_src, r_unexp, r_timeout;
  logic w_pick_d, w_grant, w_ack;
  assign w_grant = (r_state == IDLE) && (i_req_val || d_req_val);
  assign w_ack = (r_state == WAIT_RESP) && m_ack_val;
`ifdef CORE_MEM_ARB_RR_EN
  logic r_last_src;
  assign w_pick_d = d_req_val && (!i_req_val || !r_last_src);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last_src <= 1'b0;
    else if (w_grant) r_last_src <= w_pick_d;
  end
`else
  assign w_pick_d = d_req_val;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (i_req_val || d_req_val) w_next = ISSUE;
      ISSUE:     if (m_req_rdy) w_next = WAIT_RESP;
      WAIT_RESP: if (m_ack_val) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_cop     <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      r_src     <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_cnt     <= '0;
      r_unexp   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_grant) begin
        r_addr  <= w_pick_d ? d_req_addr : i_req_addr;
        r_cop   <= w_pick_d ? d_req_cop : 3'b000;
        r_wdata <= w_pick_d ? d_req_wdata : 32'h0;
        r_size  <= w_pick_d ? d_req_size : 3'b010;
        r_src   <= w_pick_d;
      end
      if (w_ack && !r_src) r_i_rdata <= m_ack_rdata;
      if (w_ack && r_src) r_d_rdata <= m_ack_rdata;
      if (m_ack_val && r_state != WAIT_RESP) r_unexp <= 1'b1;
      // With TIMEOUT_CYCLES == 0 the saturation value is 0, so the counter never moves.
      if (r_state == ISSUE && m_req_rdy) r_cnt <= '0;
      else if (r_state == WAIT_RESP && !m_ack_val && r_cnt != CW'(TIMEOUT_CYCLES)) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
      end
    end
  end
  assign m_req_val     = (r_state == ISSUE);
  assign m_req_addr    = r_addr;
  assign m_req_cop     = r_cop;
  assign m_req_wdata   = r_wdata;
  assign m_req_size    = r_size;
  assign m_req_src     = r_src;
  assign i_req_ack     = w_ack && !r_src;
  assign d_req_ack     = w_ack && r_src;
  assign i_ack_rdata   = i_req_ack ? m_ack_rdata : r_i_rdata;
  assign d_ack_rdata   = d_req_ack ? m_ack_rdata : r_d_rdata;
  assign err_unexp_ack = r_unexp;
  assign err_timeout   = r_timeout;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed vector table, hand-written corner sequences and a randomized
// run against a transaction-level reference model of the memory arbiter.
module tb_core_mem_arbiter;
  localparam int TMO = 8;
  logic clk = 1'b0, rst_n;
  logic iv, dv, rdy, av;
  logic [31:0] ia, da, dw, ar;
  logic [2:0] dc, ds;
  logic i_req_ack, d_req_ack, m_req_val, m_req_src, err_unexp_ack, err_timeout;
  logic [31:0] i_ack_rdata, d_ack_rdata, m_req_addr, m_req_wdata;
  logic [2:0] m_req_cop, m_req_size;
  int checks = 0, errors = 0;

  core_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(iv), .i_req_addr(ia), .i_req_ack(i_req_ack), .i_ack_rdata(i_ack_rdata),
    .d_req_val(dv), .d_req_addr(da), .d_req_cop(dc), .d_req_wdata(dw), .d_req_size(ds),
    .d_req_ack(d_req_ack), .d_ack_rdata(d_ack_rdata),
    .m_req_val(m_req_val), .m_req_rdy(rdy), .m_req_addr(m_req_addr), .m_req_cop(m_req_cop),
    .m_req_wdata(m_req_wdata), .m_req_size(m_req_size), .m_req_src(m_req_src),
    .m_ack_val(av), .m_ack_rdata(ar),
    .err_unexp_ack(err_unexp_ack), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iv = 1'b0; ia = '0; dv = 1'b0; da = '0; dc = '0; dw = '0; ds = '0;
    rdy = 1'b0; av = 1'b0; ar = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic iv; logic [31:0] ia; logic dv; logic [31:0] da; logic [2:0] dc; logic [31:0] dw;
    logic [2:0] ds; logic rdy; logic av; logic [31:0] ar;
    logic ev; logic [31:0] ea; logic [2:0] ec; logic [2:0] es; logic [31:0] ew; logic esrc;
    logic eia; logic [31:0] eir; logic ci; logic eda; logic [31:0] edr; logic cd;
  } vec_t;
  vec_t vt[11];

  typedef struct {
    logic src; logic [31:0] addr; logic [2:0] cop; logic [31:0] wdata; logic [2:0] size; logic acc;
  } txn_t;
  txn_t pend[$];

  initial begin
    logic e_unexp, e_tmo, have_i, have_d, i_rel, d_rel, last_src, busy_acc, ack_now, was_empty, win_d;
    logic [31:0] e_ir, e_dr;
    int wt;
    vt[0]  = '{1'b1,32'h100,1'b0,32'h0,3'd0,32'h0,3'd0,1'b1,1'b0,32'h0, 1'b0,32'h0,3'd0,3'd0,32'h0,1'b0, 1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0};
    vt[1]  = '{1'b1,32'h100,1'b0,32'h0,3'd0,32'h0,3'd0,1'b1,1'b0,32'h0, 1'b1,32'h100,3'd0,3'd2,32'h0,1'b0, 1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0};
    vt[2]  = '{1'b1,32'h100,1'b0,32'h0,3'd0,32'h0,3'd0,1'b1,1'b1,32'h13, 1'b0,32'h0,3'd0,3'd0,32'h0,1'b0, 1'b1,32'h13,1'b1, 1'b0,32'h0,1'b0};
    vt[3]  = '{1'b0,32'h0,1'b0,32'h0,3'd0,32'h0,3'd0,1'b1,1'b0,32'h0, 1'b0,32'h0,3'd0,3'd0,32'h0,1'b0, 1'b0,32'h13,1'b1, 1'b0,32'h0,1'b0};
    vt[4]  = '{1'b1,32'h200,1'b1,32'h1000,3'd2,32'h1234,3'd1,1'b1,1'b0,32'h0, 1'b0,32'h0,3'd0,3'd0,32'h0,1'b0, 1'b0,32'h13,1'b1, 1'b0,32'h0,1'b0};
    vt[5]  = '{1'b1,32'h200,1'b1,32'h1000,3'd2,32'h1234,3'd1,1'b1,1'b0,32'h0, 1'b1,32'h1000,3'd2,3'd1,32'h1234,1'b1, 1'b0,32'h13,1'b1, 1'b0,32'h0,1'b0};
    vt[6]  = '{1'b1,32'h200,1'b1,32'h1000,3'd2,32'h1234,3'd1,1'b1,1'b1,32'hAAAA_0001, 1'b0,32'h0,3'd0,3'd0,32'h0,1'b0, 1'b0,32'h13,1'b1, 1'b1,32'hAAAA_0001,1'b1};
    vt[7]  = '{1'b1,32'h200,1'b0,32'h0,3'd0,32'h0,3'd0,1'b1,1'b0,32'h0, 1'b0,32'h0,3'd0,3'd0,32'h0,1'b0, 1'b0,32'h13,1'b1, 1'b0,32'hAAAA_0001,1'b1};
    vt[8]  = '{1'b1,32'h200,1'b0,32'h0,3'd0,32'h0,3'd0,1'b1,1'b0,32'h0, 1'b1,32'h200,3'd0,3'd2,32'h0,1'b0, 1'b0,32'h13,1'b1, 1'b0,32'hAAAA_0001,1'b1};
    vt[9]  = '{1'b1,32'h200,1'b0,32'h0,3'd0,32'h0,3'd0,1'b1,1'b1,32'h55, 1'b0,32'h0,3'd0,3'd0,32'h0,1'b0, 1'b1,32'h55,1'b1, 1'b0,32'hAAAA_0001,1'b1};
    vt[10] = '{1'b0,32'h0,1'b0,32'h0,3'd0,32'h0,3'd0,1'b1,1'b0,32'h0, 1'b0,32'h0,3'd0,3'd0,32'h0,1'b0, 1'b0,32'h55,1'b1, 1'b0,32'hAAAA_0001,1'b1};

    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst m_req_val", m_req_val, 0);
    chk("rst m_req_addr", m_req_addr, 0);
    chk("rst m_req_cop", m_req_cop, 0);
    chk("rst m_req_wdata", m_req_wdata, 0);
    chk("rst m_req_size", m_req_size, 0);
    chk("rst m_req_src", m_req_src, 0);
    chk("rst acks", {i_req_ack, d_req_ack}, 0);
    chk("rst errs", {err_unexp_ack, err_timeout}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      iv = vt[k].iv; ia = vt[k].ia; dv = vt[k].dv; da = vt[k].da; dc = vt[k].dc;
      dw = vt[k].dw; ds = vt[k].ds; rdy = vt[k].rdy; av = vt[k].av; ar = vt[k].ar;
      #1;
      chk($sformatf("v%0d m_req_val", k), m_req_val, vt[k].ev);
      if (vt[k].ev) begin
        chk($sformatf("v%0d m_req_addr", k), m_req_addr, vt[k].ea);
        chk($sformatf("v%0d m_req_cop", k), m_req_cop, vt[k].ec);
        chk($sformatf("v%0d m_req_size", k), m_req_size, vt[k].es);
        chk($sformatf("v%0d m_req_wdata", k), m_req_wdata, vt[k].ew);
        chk($sformatf("v%0d m_req_src", k), m_req_src, vt[k].esrc);
      end
      chk($sformatf("v%0d i_req_ack", k), i_req_ack, vt[k].eia);
      chk($sformatf("v%0d d_req_ack", k), d_req_ack, vt[k].eda);
      if (vt[k].ci) chk($sformatf("v%0d i_ack_rdata", k), i_ack_rdata, vt[k].eir);
      if (vt[k].cd) chk($sformatf("v%0d d_ack_rdata", k), d_ack_rdata, vt[k].edr);
    end

    // write held off by 5 cycles of backpressure; late field changes must be ignored
    do_reset();
    @(negedge clk);
    dv = 1'b1; da = 32'h2000; dc = 3'b001; dw = 32'hDEAD_BEEF; ds = 3'd2; rdy = 1'b0;
    #1;
    chk("bp idle m_req_val", m_req_val, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) begin da = 32'hFFFF_0000; dw = 32'h0; end
      #1;
      chk($sformatf("bp%0d m_req_val", k), m_req_val, 1);
      chk($sformatf("bp%0d m_req_addr", k), m_req_addr, 32'h2000);
      chk($sformatf("bp%0d m_req_cop", k), m_req_cop, 3'b001);
      chk($sformatf("bp%0d m_req_wdata", k), m_req_wdata, 32'hDEAD_BEEF);
      chk($sformatf("bp%0d m_req_size", k), m_req_size, 3'd2);
      chk($sformatf("bp%0d m_req_src", k), m_req_src, 1);
    end
    @(negedge clk); rdy = 1'b1; #1;
    chk("bp accept m_req_val", m_req_val, 1);
    @(negedge clk); rdy = 1'b0; #1;
    chk("bp wait m_req_val", m_req_val, 0);
    chk("bp wait d_req_ack", d_req_ack, 0);
    @(negedge clk); av = 1'b1; ar = 32'h0; #1;
    chk("bp ack d_req_ack", d_req_ack, 1);
    chk("bp ack i_req_ack", i_req_ack, 0);
    @(negedge clk); av = 1'b0; dv = 1'b0; #1;
    chk("bp after d_req_ack", d_req_ack, 0);

    // spurious response while idle
    @(negedge clk); av = 1'b1; ar = 32'h1111_2222; #1;
    chk("ua acks", {i_req_ack, d_req_ack}, 0);
    chk("ua err before edge", err_unexp_ack, 0);
    @(negedge clk); av = 1'b0; iv = 1'b1; ia = 32'h300; rdy = 1'b1; #1;
    chk("ua err set", err_unexp_ack, 1);
    @(negedge clk); #1;
    chk("ua fetch m_req_val", m_req_val, 1);
    chk("ua fetch m_req_addr", m_req_addr, 32'h300);
    @(negedge clk); av = 1'b1; ar = 32'h77; #1;
    chk("ua fetch i_req_ack", i_req_ack, 1);
    chk("ua fetch i_ack_rdata", i_ack_rdata, 32'h77);
    @(negedge clk); av = 1'b0; iv = 1'b0; #1;
    chk("ua err sticky", err_unexp_ack, 1);

    // response withheld past the timeout
    do_reset();
    @(negedge clk); iv = 1'b1; ia = 32'h400; rdy = 1'b1; #1;
    @(negedge clk); #1;
    chk("to issue m_req_val", m_req_val, 1);
    for (int w = 1; w <= TMO; w++) begin
      @(negedge clk); #1;
      chk($sformatf("to wait%0d err_timeout", w), err_timeout, 0);
      chk($sformatf("to wait%0d i_req_ack", w), i_req_ack, 0);
    end
    @(negedge clk); av = 1'b1; ar = 32'h99; #1;
    chk("to err_timeout set", err_timeout, 1);
    chk("to late i_req_ack", i_req_ack, 1);
    chk("to late i_ack_rdata", i_ack_rdata, 32'h99);
    @(negedge clk); av = 1'b0; iv = 1'b0; #1;
    chk("to err sticky", err_timeout, 1);

    // asynchronous reset while waiting for a response
    @(negedge clk); av = 1'b1; #1;
    @(negedge clk); av = 1'b0; iv = 1'b1; ia = 32'h500; rdy = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); av = 1'b1; ar = 32'hBAD; #1;
    chk("mr errs before", {err_unexp_ack, err_timeout}, 2'b11);
    chk("mr i_req_ack before", i_req_ack, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr m_req_val", m_req_val, 0);
    chk("mr m_req_addr", m_req_addr, 0);
    chk("mr acks", {i_req_ack, d_req_ack}, 0);
    chk("mr errs", {err_unexp_ack, err_timeout}, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); iv = 1'b1; ia = 32'h600; rdy = 1'b1; #1;
    chk("mr idle m_req_val", m_req_val, 0);
    @(negedge clk); #1;
    chk("mr fetch m_req_val", m_req_val, 1);
    chk("mr fetch m_req_addr", m_req_addr, 32'h600);
    @(negedge clk); av = 1'b1; ar = 32'h66; #1;
    chk("mr fetch i_req_ack", i_req_ack, 1);
    chk("mr fetch i_ack_rdata", i_ack_rdata, 32'h66);

    // randomized traffic against the transaction-level model
    do_reset();
    pend.delete();
    e_unexp = 1'b0; e_tmo = 1'b0; have_i = 1'b0; have_d = 1'b0; i_rel = 1'b0; d_rel = 1'b0;
    last_src = 1'b0; e_ir = '0; e_dr = '0; wt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (i_rel) iv = 1'b0;
      if (d_rel) dv = 1'b0;
      i_rel = 1'b0; d_rel = 1'b0;
      if (!iv && $urandom_range(3) != 0) begin iv = 1'b1; ia = $urandom; end
      if (!dv && $urandom_range(2) == 0) begin
        dv = 1'b1; da = $urandom; dw = $urandom; dc = 3'($urandom_range(7)); ds = 3'($urandom_range(7));
      end
      rdy = $urandom_range(2) != 0;
      busy_acc = pend.size() != 0 && pend[0].acc;
      av = busy_acc ? (wt >= 3 || $urandom_range(1) == 1) : ($urandom_range(15) == 0);
      ar = $urandom;
      #1;
      chk("rnd m_req_val", m_req_val, pend.size() != 0 && !pend[0].acc);
      if (pend.size() != 0 && !pend[0].acc) begin
        chk("rnd m_req_addr", m_req_addr, pend[0].addr);
        chk("rnd m_req_cop", m_req_cop, pend[0].cop);
        chk("rnd m_req_wdata", m_req_wdata, pend[0].wdata);
        chk("rnd m_req_size", m_req_size, pend[0].size);
        chk("rnd m_req_src", m_req_src, pend[0].src);
      end
      ack_now = busy_acc && av;
      chk("rnd i_req_ack", i_req_ack, ack_now && !pend[0].src);
      chk("rnd d_req_ack", d_req_ack, ack_now && pend[0].src);
      if (ack_now && !pend[0].src) chk("rnd i_ack_rdata", i_ack_rdata, ar);
      else if (have_i) chk("rnd i_ack_rdata hold", i_ack_rdata, e_ir);
      if (ack_now && pend[0].src) chk("rnd d_ack_rdata", d_ack_rdata, ar);
      else if (have_d) chk("rnd d_ack_rdata hold", d_ack_rdata, e_dr);
      chk("rnd err_unexp_ack", err_unexp_ack, e_unexp);
      chk("rnd err_timeout", err_timeout, e_tmo);
      was_empty = pend.size() == 0;
      if (ack_now) begin
        if (pend[0].src) begin e_dr = ar; have_d = 1'b1; d_rel = 1'b1; end
        else begin e_ir = ar; have_i = 1'b1; i_rel = 1'b1; end
        pend.pop_front();
      end else if (av) e_unexp = 1'b1;
      if (busy_acc && !av) begin
        wt++;
        if (wt == TMO) e_tmo = 1'b1;
      end
      if (pend.size() != 0 && !pend[0].acc && rdy) begin pend[0].acc = 1'b1; wt = 0; end
      if (was_empty && (iv || dv)) begin
`ifdef CORE_MEM_ARB_RR_EN
        win_d = (iv && dv) ? !last_src : dv;
        last_src = win_d;
`else
        win_d = dv;
`endif
        pend.push_back('{win_d, win_d ? da : ia, win_d ? dc : 3'b000, win_d ? dw : 32'h0,
                         win_d ? ds : 3'b010, 1'b0});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Sits directly downstream of core_top and merges its instruction port (i_req_*) and data port (d_req_*) onto one split-transaction memory port (m_req_*/m_ack_*) toward the fabric.
- Only one transaction is outstanding at a time.
- Requests are latched and re-driven until accepted. The response is routed back to the requesting port as a single-cycle ack with its read data.

Parameters:
- TIMEOUT_CYCLES, default 1024: number of WAIT_RESP cycles before err_timeout is set. 0 disables the check.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_req_val  input  1  instruction request; held until i_req_ack
- i_req_addr  input  32  instruction address
- i_req_ack  output  1  one-cycle ack; i_ack_rdata is valid in the same cycle
- i_ack_rdata  output  32  instruction read data
- d_req_val  input  1  data request; held until d_req_ack
- d_req_addr  input  32  data address
- d_req_cop  input  3  {rsvd, nc, wr}
- d_req_wdata  input  32  write data
- d_req_size  input  3  access size
- d_req_ack  output  1  one-cycle ack
- d_ack_rdata  output  32  data read data
- m_req_val  output  1  memory request valid
- m_req_rdy  input  1  memory accepts when m_req_val & m_req_rdy
- m_req_addr  output  32  latched address
- m_req_cop  output  3  latched cop; 3'b000 for instruction fetches
- m_req_wdata  output  32  latched write data; 0 for fetches
- m_req_size  output  3  latched size; 3'b010 (word) for fetches
- m_req_src  output  1  0 = instruction, 1 = data
- m_ack_val  input  1  response valid; returned for reads and writes
- m_ack_rdata  input  32  response data
- err_unexp_ack  output  1  sticky: m_ack_val seen outside WAIT_RESP
- err_timeout  output  1  sticky: TIMEOUT_CYCLES exceeded in WAIT_RESP

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - All m_req_* outputs = 0.
  - i_req_ack, d_req_ack, both err flags and the timeout counter = 0.
  - An outstanding transaction is dropped. The fabric shares rst_n.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If d_req_val or i_req_val, latch the winner's fields and the src bit, then go to ISSUE.
  - Default arbitration is fixed priority, data over instruction.
  - m_req_val = 0 in IDLE.
- ISSUE:
  - m_req_val = 1 and all m_req_* fields are driven from registers, stable until accepted.
  - On m_req_rdy go to WAIT_RESP and clear the timeout counter.
  - Upstream inputs are ignored in this state.
- WAIT_RESP:
  - On m_ack_val, drive the ack of the latched src combinationally in that cycle. Route m_ack_rdata combinationally to the matching *_ack_rdata. Go to IDLE.
  - The other port's ack stays 0.
- Latency:
  - The request is sampled in IDLE at edge 0 and m_req_val rises in cycle 1.
  - Minimum upstream latency is 3 cycles: request, then issue with rdy = 1, then an ack in the first WAIT_RESP cycle.
- Back-to-back: after an ack, the next cycle is IDLE and samples the upstream again. Because i_req_val is constantly 1, fetches re-arbitrate every 3 cycles minimum.
- Outside WAIT_RESP:
  - Acks are forced to 0.
  - *_ack_rdata hold their last value. The data registers are updated only on an ack.
- err_unexp_ack: set when m_ack_val = 1 in IDLE or ISSUE. The response is discarded and the FSM is unaffected.
- Timeout counter:
  - Counts cycles in WAIT_RESP and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets err_timeout. The FSM keeps waiting; there is no auto-ack.
- Error flags are cleared only by reset.
- Upstream requirement: a request must be held stable from val until its ack. Changes to fields after latching are ignored.

Optional Feature:
- Macro: CORE_MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a last_src register (reset 0 = instruction). When both ports request in IDLE, the port not equal to last_src wins.
  - last_src updates on entry to ISSUE.
  - A single requester always wins.
- Undefined: fixed priority, data over instruction, and no last_src register.

Test Plan:
- Fetch only:
  - Stimulus: i_req_val = 1, addr 0x0000_0100; m_req_rdy = 1; m_ack_val one cycle after accept with rdata 0x0000_0013.
  - Response: m_req_addr = 0x100, cop = 0, size = 2, src = 0; i_req_ack pulses with i_ack_rdata = 0x13 in cycle 3; d_req_ack = 0.
- Simultaneous requests:
  - Stimulus: i 0x200 and d-read 0x1000 asserted together.
  - Response: data is issued first (src = 1); the fetch issues after d_req_ack. With CORE_MEM_ARB_RR_EN defined, the grant order over two rounds is data, then instruction, then data.
- Write backpressure:
  - Stimulus: d-write cop 3'b001, addr 0x2000, wdata 0xDEAD_BEEF, size 2; m_req_rdy = 0 for 5 cycles.
  - Response: m_req_val and all fields stay stable for those 5 cycles; acceptance happens on the rdy cycle; d_req_ack pulses only on m_ack_val.
- Unexpected ack:
  - Stimulus: m_ack_val pulse while in IDLE.
  - Response: err_unexp_ack = 1 and stays set; no upstream ack; the next transaction completes normally.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8; accept a request and withhold m_ack_val.
  - Response: err_timeout = 1 after 8 WAIT_RESP cycles; a late m_ack_val still acks the requester.
- Reset mid-transaction:
  - Stimulus: assert rst_n low in WAIT_RESP, asynchronously between clock edges.
  - Response: m_req_val = 0, acks = 0, err flags = 0 immediately; after release, the FSM is in IDLE and serves a new fetch normally.
